// File: rtl/parity_frame_controller.sv
// parity_frame_controller
// Byte-stream framer: forwards data bytes through a one-deep output register
// and appends one trailer byte {byte_count[6:0], parity} after each frame.
module parity_frame_controller #(
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   odd_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic                   out_last,
  output logic                   out_is_trailer,
  output logic [FRAME_CNT_W-1:0] frames_done,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIL = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   par_q, par_d;
  logic [6:0]             cnt_q, cnt_d;
  logic                   mode_q, mode_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;
  logic [FRAME_CNT_W-1:0] frames_q, frames_d;

  logic slot_free;
  logic in_fire;
  logic out_fire;
  logic byte_par;

  // Handshake qualifiers; the output slot can drain and refill in one cycle.
  always_comb begin
    slot_free = ~out_valid_q | out_ready;
    in_ready  = (state_q != TRAIL) & slot_free;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid_q & out_ready;
    byte_par  = ^in_data;
  end

  // State and datapath registers, cleared asynchronously (drops any open frame).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      par_q       <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frames_q    <= frames_d;
    end
  end

  // Next-state: frame sequencing, parity/count accumulation and output-slot loading.
  always_comb begin
    state_d     = state_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frames_d    = frames_q;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          // First byte of a frame: mode is captured here and held to the trailer.
          mode_d  = odd_mode;
          par_d   = byte_par;
          cnt_d   = 7'd1;
          state_d = in_last ? TRAIL : DATA;
        end
      end
      DATA: begin
        if (in_fire) begin
          par_d = par_q ^ byte_par;
          cnt_d = cnt_q + 7'd1;
          if (in_last) begin
            state_d = TRAIL;
          end
        end
      end
      TRAIL: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = {cnt_q, par_q ^ mode_q};
          out_last_d  = 1'b1;
          par_d       = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_last_d  = 1'b0;
    end

    if (out_fire && out_last_q) begin
      frames_d = frames_q + FRAME_CNT_W'(1);
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid      = out_valid_q;
    out_data       = out_data_q;
    out_last       = out_last_q;
    out_is_trailer = out_last_q;
    frames_done    = frames_q;
    busy           = (state_q != IDLE) | out_valid_q;
  end

endmodule

// File: tb/tb_parity_frame_controller.sv
// tb_parity_frame_controller
// Directed frames checked against a frame-level model: expected output stream
// (data bytes then trailer built from the whole frame), frames-accepted count,
// in_ready/busy rules and output hold under backpressure.
module tb_parity_frame_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        odd_mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_is_trailer;
  logic [15:0] frames_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;

  parity_frame_controller #(.FRAME_CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .odd_mode       (odd_mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_is_trailer (out_is_trailer),
    .frames_done    (frames_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Sink readiness policy: 0 = always ready, 1 = stalled, 2 = alternating.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ~out_ready;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model state
  logic [9:0]  exp_q[$];      // {is_trailer, last, byte}
  logic [7:0]  frame_q[$];
  logic        frame_mode;
  logic        pend = 1'b0;   // trailer owed but not yet in the output slot
  logic [15:0] fd_model = '0;
  logic [7:0]  model_trailer = '0;
  logic        prev_v = 1'b0;
  logic        prev_r = 1'b0;
  logic [7:0]  prev_d = '0;

  always @(negedge clk) begin
    int          ones;
    logic [9:0]  e;
    logic        slot;
    if (!rst_n) begin
      exp_q.delete();
      frame_q.delete();
      pend     = 1'b0;
      fd_model = '0;
      prev_v   = 1'b0;
      prev_r   = 1'b0;
    end else begin
      slot = ~out_valid | out_ready;
      chk("in_ready", in_ready, !pend && slot);
      chk("busy", busy, pend || (frame_q.size() > 0) || out_valid);
      chk("frames_done", frames_done, fd_model);
      chk("trailer_flags_agree", out_is_trailer, out_last);
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[7:0]);
          chk("out_last", out_last, e[8]);
          chk("out_is_trailer", out_is_trailer, e[9]);
          if (e[9]) fd_model = fd_model + 16'd1;
        end
      end
      if (pend && slot) pend = 1'b0;
      if (in_valid && in_ready) begin
        if (frame_q.size() == 0) frame_mode = odd_mode;
        frame_q.push_back(in_data);
        exp_q.push_back({2'b00, in_data});
        if (in_last) begin
          ones = 0;
          foreach (frame_q[i]) ones += $countones(frame_q[i]);
          model_trailer = {7'(frame_q.size() % 128), 1'((ones % 2) ^ int'(frame_mode))};
          exp_q.push_back({2'b11, model_trailer});
          frame_q.delete();
          pend = 1'b1;
        end
      end
      prev_v = out_valid;
      prev_r = out_ready;
      prev_d = out_data;
    end
  end

  task automatic send(input logic [7:0] d, input logic l, input logic m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    odd_mode = m;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (busy || exp_q.size() != 0) chk("drain_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_is_trailer", out_is_trailer, 1'b0);
    chk("rst_frames_done", frames_done, 16'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Even frame 0x01, 0x03
    send(8'h01, 1'b0, 1'b0);
    send(8'h03, 1'b1, 1'b0);
    wait_idle();
    chk("even_trailer", model_trailer, 8'h05);
    chk("even_fd", frames_done, 16'd1);

    // Odd mode latched at first byte, toggled afterwards
    send(8'h01, 1'b0, 1'b1);
    send(8'h03, 1'b1, 1'b0);
    wait_idle();
    chk("odd_trailer", model_trailer, 8'h04);

    // Single-byte frames back to back
    send(8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("trail_in_ready_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("single_ff_trailer", model_trailer, 8'h02);
    send(8'h80, 1'b1, 1'b0);
    wait_idle();
    chk("single_80_trailer", model_trailer, 8'h03);
    chk("single_fd", frames_done, 16'd4);

    // Count wrap: 128 bytes of 0x01
    for (int i = 0; i < 128; i++) send(8'h01, (i == 127), 1'b0);
    wait_idle();
    chk("wrap_trailer", model_trailer, 8'h00);

    // Backpressure mid-frame
    send(8'h11, 1'b0, 1'b0);
    rdy_mode = 1;
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_out_data", out_data, 8'h11);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0);
    wait_idle();
    chk("bp_trailer", model_trailer, 8'h06);

    // Full throughput
    c0 = cyc;
    for (int i = 1; i <= 6; i++) send(8'(i), (i == 6), 1'b0);
    chk("throughput_cycles", cyc - c0, 6);
    wait_idle();
    chk("tput_trailer", model_trailer, 8'h0D);

    // Alternating sink readiness
    rdy_mode = 2;
    send(8'hA5, 1'b0, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    wait_idle();
    rdy_mode = 0;
    chk("alt_trailer", model_trailer, 8'h04);
    chk("alt_fd", frames_done, 16'd8);

    // Reset mid-frame
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_fd", frames_done, 16'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h07, 1'b1, 1'b0);
    wait_idle();
    chk("post_rst_trailer", model_trailer, 8'h03);
    chk("post_rst_fd", frames_done, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
